// File: rtl/montgomery_pkg.sv
// Shared types and constants for the Montgomery multiplier.
// Holds the default width, FSM state encoding and counter sizing.
package montgomery_pkg;

    localparam int MONT_WIDTH = 512;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SUB,
        DONE
    } state_t;

    function automatic int mont_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int MONT_CNT_W = mont_cnt_w(MONT_WIDTH);

endpackage

// File: rtl/montgomery_step.sv
// One radix-2 Montgomery iteration: conditionally add B, then add M
// when the sum is odd so the halving step is exact.
module montgomery_step
    import montgomery_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH
) (
    input  logic [WIDTH+1:0] i_t,
    input  logic             i_ai,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH+1:0] o_t
);

    logic [WIDTH+1:0] w_s;
    logic [WIDTH+1:0] w_u;

    // T + a_i*B, then + q*M, then halve; T < 2M keeps this within WIDTH+2 bits
    always_comb begin
        w_s = i_t + (i_ai ? {2'b00, i_b} : '0);
        w_u = w_s + (w_s[0] ? {2'b00, i_m} : '0);
        o_t = w_u >> 1;
    end

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// MONTGOMERY_DONE_HOLD_EN: done held high until the next accepted start.
module montgomery_mult
    import montgomery_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int CW = mont_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH+1:0] r_t;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_done;

    logic [WIDTH+1:0] w_t_next;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    montgomery_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_t  (r_t),
        .i_ai (r_a[0]),
        .i_b  (r_b),
        .i_m  (r_m),
        .o_t  (w_t_next)
    );

    assign w_ge   = (r_t >= {2'b00, r_m});
    assign w_sub  = WIDTH'(r_t - {2'b00, r_m});
    assign result = r_result;
    assign done   = r_done;

    // Control FSM with operand, accumulator, result and done registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_t      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
`ifndef MONTGOMERY_DONE_HOLD_EN
                    r_done <= 1'b0;
`endif
                    if (start) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_m     <= in_m;
                        r_t     <= '0;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_done <= 1'b0;
                    r_t    <= w_t_next;
                    r_a    <= r_a >> 1;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= SUB;
                    end
                end
                SUB: begin
                    r_done   <= 1'b0;
                    r_result <= w_ge ? w_sub : r_t[WIDTH-1:0];
                    r_state  <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_mult.sv
// Directed and randomized checks for montgomery_mult.
// Expected values are hand-derived using moduli dividing 2^512-1.
module tb_montgomery_mult;
    import montgomery_pkg::*;

    localparam int W = MONT_WIDTH;
    localparam int LAT = W + 2;
`ifdef MONTGOMERY_DONE_HOLD_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] m;
        logic [W-1:0] exp;
    } vec_t;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] in_m;
    logic [W-1:0] result;
    logic         done;

    int n_total;
    int n_pass;

    montgomery_mult #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_a   (in_a),
        .in_b   (in_b),
        .in_m   (in_m),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd512();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] m, input int poke_at,
                         output logic [W-1:0] res,
                         output logic [W-1:0] mid, output int cyc);
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        in_m  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_a  = rnd512();
        in_b  = rnd512();
        in_m  = rnd512();
        cyc   = 0;
        mid   = '0;
        while (cyc < 600) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (cyc == poke_at) begin
                mid   = result;
                start = 1'b1;
            end
            if (done) break;
        end
        start = 1'b0;
        res   = result;
    endtask

    vec_t         vecs[8];
    logic [W-1:0] m1;
    logic [W-1:0] res;
    logic [W-1:0] res2;
    logic [W-1:0] mid;
    logic [W-1:0] prev;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rm;
    logic [2*W-1:0] lhs;
    logic [2*W-1:0] rhs;
    int           cyc;

    initial begin
        n_total = 0;
        n_pass  = 0;
        m1      = '1;

        vecs[0] = '{a: 512'd2, b: 512'd3, m: m1, exp: 512'd6};
        vecs[1] = '{a: 512'd0, b: 512'd5, m: m1, exp: 512'd0};
        vecs[2] = '{a: 512'd2, b: 512'd2, m: 512'd3, exp: 512'd1};
        vecs[3] = '{a: 512'd1 << 511, b: 512'd2, m: m1, exp: 512'd1};
        vecs[4] = '{a: m1 - 512'd1, b: m1 - 512'd1, m: m1, exp: 512'd1};
        vecs[5] = '{a: 512'd1 << 255, b: 512'd4,
                    m: (512'd1 << 256) + 512'd1,
                    exp: (512'd1 << 256) - 512'd1};
        vecs[6] = '{a: 512'd3, b: 512'd4, m: 512'd5, exp: 512'd2};
        vecs[7] = '{a: 512'd256, b: 512'd256, m: 512'd65537,
                    exp: 512'd65536};

        resetn = 1'b0;
        start  = 1'b0;
        in_a   = '0;
        in_b   = '0;
        in_m   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, '0);
        chk("reset_done", {511'd0, done}, '0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].m, -1, res, mid, cyc);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), W'(cyc), W'(LAT));
        end

        @(posedge clk);
        #1;
        chk("done_after_idle", {511'd0, done}, {511'd0, HOLD});
        chk("result_hold_idle", result, vecs[7].exp);

        do_op(vecs[5].a, vecs[5].b, vecs[5].m, -1, res, mid, cyc);
        do_op(vecs[5].a, vecs[5].b, vecs[5].m, -1, res2, mid, cyc);
        chk("b2b_result", res2, vecs[5].exp);
        chk("b2b_latency", W'(cyc), W'(LAT));

        prev = res2;
        do_op(vecs[0].a, vecs[0].b, vecs[0].m, 50, res, mid, cyc);
        chk("busy_start_hold", mid, prev);
        chk("busy_start_result", res, vecs[0].exp);
        chk("busy_start_latency", W'(cyc), W'(LAT));

        @(negedge clk);
        in_a  = vecs[7].a;
        in_b  = vecs[7].b;
        in_m  = vecs[7].m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("abort_result", result, '0);
        chk("abort_done", {511'd0, done}, '0);
        @(negedge clk);
        resetn = 1'b1;
        do_op(vecs[2].a, vecs[2].b, vecs[2].m, -1, res, mid, cyc);
        chk("after_abort_result", res, vecs[2].exp);
        chk("after_abort_latency", W'(cyc), W'(LAT));

        for (int k = 0; k < 6; k++) begin
            rm = rnd512();
            rm[0] = 1'b1;
            rm[W-1] = 1'b1;
            ra = rnd512() % rm;
            rb = rnd512() % rm;
            do_op(ra, rb, rm, -1, res, mid, cyc);
            lhs = ({{W{1'b0}}, res} << W) % {{W{1'b0}}, rm};
            rhs = ({{W{1'b0}}, ra} * {{W{1'b0}}, rb}) % {{W{1'b0}}, rm};
            chk($sformatf("rnd%0d_range", k), {511'd0, (res < rm)}, 512'd1);
            chk($sformatf("rnd%0d_congruence", k), lhs[W-1:0], rhs[W-1:0]);
            chk($sformatf("rnd%0d_latency", k), W'(cyc), W'(LAT));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
